// File: rtl/program_loader_if.sv
// Boot byte stream in, program memory write port out.
// The loader sits on the slave side; the stream source / memory side uses master.
interface program_loader_if;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        prog_we_o;
    logic [31:0] prog_addr_o;
    logic [31:0] prog_wdata_o;

    modport slave (
        input  byte_valid_i,
        input  byte_data_i,
        output byte_ready_o,
        output prog_we_o,
        output prog_addr_o,
        output prog_wdata_o
    );

    modport master (
        output byte_valid_i,
        output byte_data_i,
        input  byte_ready_o,
        input  prog_we_o,
        input  prog_addr_o,
        input  prog_wdata_o
    );
endinterface

// File: rtl/program_loader.sv
// Loads a length-prefixed little-endian word stream into program memory, holding the core in reset meanwhile.
// One write cycle after every 4th byte (5 cycles/word minimum); byte_ready drops during that write cycle.
module program_loader #(
    parameter int PROGRAM_MEMORY_DEPTH = 64,
    parameter int TIMEOUT_CYCLES       = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              run_i,
    program_loader_if.slave   bus,
    output logic              core_reset_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);
    localparam int WI_W = $clog2(PROGRAM_MEMORY_DEPTH) + 1;
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [15:0]       r_count;
    logic [WI_W-1:0]   r_word_index;
    logic [1:0]        r_byte_index;
    logic [31:0]       r_word;
    logic [TO_W-1:0]   r_to_cnt;

    logic              w_ready;
    logic              w_xfer;
    logic [15:0]       w_len;
    logic              w_len_bad;
    logic [WI_W-1:0]   w_wi_next;
    logic              w_last_word;
    logic              w_timeout;
    logic              w_enter_len_lo;

    assign w_ready     = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) || (r_state == S_DATA);
    assign w_xfer      = bus.byte_valid_i && w_ready;
    assign w_len       = {bus.byte_data_i, r_count[7:0]};
    assign w_len_bad   = (w_len == 16'd0) || (w_len > 16'(PROGRAM_MEMORY_DEPTH));
    assign w_wi_next   = r_word_index + WI_W'(1);
    assign w_last_word = ({{(16-WI_W){1'b0}}, w_wi_next} == r_count);
    // Fires on the idle cycle that would carry the counter to TIMEOUT_CYCLES-1; a transfer that cycle wins.
    assign w_timeout   = w_ready && !w_xfer && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 2));
    assign w_enter_len_lo = (w_state_next == S_LEN_LO) && (r_state != S_LEN_LO);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_next = S_LEN_LO;
                end else if (run_i) begin
                    w_state_next = S_DONE;
                end
            end
            S_LEN_LO: begin
                if (w_timeout) begin
                    w_state_next = S_ERROR;
                end else if (w_xfer) begin
                    w_state_next = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (w_timeout) begin
                    w_state_next = S_ERROR;
                end else if (w_xfer) begin
                    w_state_next = w_len_bad ? S_ERROR : S_DATA;
                end
            end
            S_DATA: begin
                if (w_timeout) begin
                    w_state_next = S_ERROR;
                end else if (w_xfer && (r_byte_index == 2'd3)) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_state_next = w_last_word ? S_DONE : S_DATA;
            end
            S_DONE, S_ERROR: begin
                if (start_i) begin
                    w_state_next = S_LEN_LO;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count      <= '0;
            r_word_index <= '0;
            r_byte_index <= '0;
            r_word       <= '0;
            r_to_cnt     <= '0;
        end else begin
            if (w_xfer || w_enter_len_lo) begin
                r_to_cnt <= '0;
            end else if (w_ready) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end

            if (w_xfer && (r_state == S_LEN_LO)) begin
                r_count[7:0] <= bus.byte_data_i;
            end

            if (w_xfer && (r_state == S_LEN_HI)) begin
                r_count[15:8] <= bus.byte_data_i;
                r_word_index  <= '0;
                r_byte_index  <= '0;
            end

            if (w_xfer && (r_state == S_DATA)) begin
                r_word[{r_byte_index, 3'b000} +: 8] <= bus.byte_data_i;
                r_byte_index <= r_byte_index + 2'd1;
            end

            if (r_state == S_WRITE) begin
                r_word_index <= w_wi_next;
            end
        end
    end

    assign bus.byte_ready_o = w_ready;
    assign bus.prog_we_o    = (r_state == S_WRITE);
    assign bus.prog_addr_o  = {{(30-WI_W){1'b0}}, r_word_index, 2'b00};
    assign bus.prog_wdata_o = r_word;

    assign core_reset_o = (r_state != S_DONE);
    assign busy_o       = w_ready || (r_state == S_WRITE);
    assign done_o       = (r_state == S_DONE);
    assign error_o      = (r_state == S_ERROR);
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: load, bad length, timeout edge, reset mid-load, run, streaming.
module tb_program_loader;
    logic clk = 1'b0;
    logic reset;
    logic start_i;
    logic run_i;
    logic core_reset_o;
    logic busy_o;
    logic done_o;
    logic error_o;

    always #5 clk = ~clk;

    program_loader_if bus();

    program_loader #(.PROGRAM_MEMORY_DEPTH(64), .TIMEOUT_CYCLES(1024)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .run_i        (run_i),
        .bus          (bus),
        .core_reset_o (core_reset_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mon_addr [0:31];
    logic [31:0] mon_data [0:31];
    int          mon_cyc  [0:31];
    int          mon_cnt = 0;

    always @(negedge clk) begin
        if (bus.prog_we_o === 1'b1) begin
            if (mon_cnt < 32) begin
                mon_addr[mon_cnt] = bus.prog_addr_o;
                mon_data[mon_cnt] = bus.prog_wdata_o;
                mon_cyc[mon_cnt]  = cyc;
            end
            mon_cnt = mon_cnt + 1;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        start_i = 1'b0;
        run_i = 1'b0;
        bus.byte_valid_i = 1'b0;
        bus.byte_data_i = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.byte_valid_i = 1'b1;
        bus.byte_data_i = b;
        @(negedge clk);
        while (bus.byte_ready_o !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_byte_ready: ready never seen for byte %h", b);
        end
        @(posedge clk);
        #1 bus.byte_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy_o, done_o, error_o, core_reset_o, bus.byte_ready_o, bus.prog_we_o} !== 6'b000100) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000100",
                     {busy_o, done_o, error_o, core_reset_o, bus.byte_ready_o, bus.prog_we_o});
        end
        checks++;
        if (bus.prog_addr_o !== 32'h0 || bus.prog_wdata_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: addr %h wdata %h want 0 0", bus.prog_addr_o, bus.prog_wdata_o);
        end
    endtask

    task automatic test_basic_load();
        logic [7:0] s [10];
        int base;
        s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'hB3, 8'h05, 8'hA5, 8'h00};
        do_reset();
        base = mon_cnt;
        pulse_start();
        checks++;
        if (busy_o !== 1'b1 || bus.byte_ready_o !== 1'b1 || core_reset_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_len_lo: busy %b ready %b core_rst %b want 1 1 1",
                     busy_o, bus.byte_ready_o, core_reset_o);
        end
        for (int i = 0; i < 10; i++) send_byte(s[i]);
        checks++;
        if (done_o !== 1'b0 || core_reset_o !== 1'b1 || bus.prog_we_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_last_write: done %b core_rst %b we %b want 0 1 1",
                     done_o, core_reset_o, bus.prog_we_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done_o !== 1'b1 || core_reset_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done %b core_rst %b busy %b want 1 0 0", done_o, core_reset_o, busy_o);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (mon_cnt - base !== 2) begin
            errors++;
            $display("FAIL basic_we_count: got %0d want 2", mon_cnt - base);
        end
        checks++;
        if (mon_addr[base] !== 32'h0 || mon_data[base] !== 32'h00500513) begin
            errors++;
            $display("FAIL basic_word0: addr %h data %h want 0 00500513", mon_addr[base], mon_data[base]);
        end
        checks++;
        if (mon_addr[base+1] !== 32'h4 || mon_data[base+1] !== 32'h00A505B3) begin
            errors++;
            $display("FAIL basic_word1: addr %h data %h want 4 00a505b3", mon_addr[base+1], mon_data[base+1]);
        end
    endtask

    task automatic test_bad_length();
        int base;
        do_reset();
        base = mon_cnt;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        checks++;
        if ({error_o, core_reset_o, busy_o} !== 3'b110) begin
            errors++;
            $display("FAIL len_zero: err/core_rst/busy %b want 110", {error_o, core_reset_o, busy_o});
        end
        pulse_start();
        checks++;
        if (error_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL err_restart: err %b busy %b want 0 1", error_o, busy_o);
        end
        send_byte(8'h41);
        send_byte(8'h00);
        checks++;
        if ({error_o, core_reset_o, busy_o} !== 3'b110) begin
            errors++;
            $display("FAIL len_65: err/core_rst/busy %b want 110", {error_o, core_reset_o, busy_o});
        end
        run_i = 1'b1;
        @(posedge clk);
        #1 run_i = 1'b0;
        checks++;
        if (error_o !== 1'b1 || core_reset_o !== 1'b1 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL err_run_ignored: err %b core_rst %b done %b want 1 1 0", error_o, core_reset_o, done_o);
        end
        checks++;
        if (mon_cnt !== base) begin
            errors++;
            $display("FAIL bad_len_writes: got %0d want 0", mon_cnt - base);
        end
    endtask

    task automatic test_timeout();
        int base;
        do_reset();
        base = mon_cnt;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h13);
        repeat (1022) @(posedge clk);
        #1;
        checks++;
        if (busy_o !== 1'b1 || error_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: busy %b err %b want 1 0", busy_o, error_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (error_o !== 1'b1 || core_reset_o !== 1'b1 || mon_cnt !== base) begin
            errors++;
            $display("FAIL timeout_hit: err %b core_rst %b writes %0d want 1 1 0",
                     error_o, core_reset_o, mon_cnt - base);
        end
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h13);
        repeat (1022) @(posedge clk);
        #1;
        send_byte(8'h05);
        send_byte(8'h00);
        send_byte(8'h00);
        @(posedge clk);
        #1;
        checks++;
        if (done_o !== 1'b1 || mon_cnt - base !== 1 || mon_data[base] !== 32'h00000513) begin
            errors++;
            $display("FAIL timeout_margin: done %b writes %0d data %h want 1 1 00000513",
                     done_o, mon_cnt - base, mon_data[base]);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] s [8];
        logic [7:0] r [6];
        int base;
        s = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        r = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        do_reset();
        base = mon_cnt;
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(s[i]);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({busy_o, done_o, error_o, core_reset_o, bus.byte_ready_o, bus.prog_we_o} !== 6'b000100
            || bus.prog_wdata_o !== 32'h0 || bus.prog_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL midreset_state: flags %b addr %h wdata %h want 000100 0 0",
                     {busy_o, done_o, error_o, core_reset_o, bus.byte_ready_o, bus.prog_we_o},
                     bus.prog_addr_o, bus.prog_wdata_o);
        end
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mon_cnt - base !== 1 || mon_addr[base] !== 32'h0 || mon_data[base] !== 32'h44332211) begin
            errors++;
            $display("FAIL midreset_writes: count %0d addr %h data %h want 1 0 44332211",
                     mon_cnt - base, mon_addr[base], mon_data[base]);
        end
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(r[i]);
        @(posedge clk);
        #1;
        checks++;
        if (done_o !== 1'b1 || mon_cnt - base !== 2 || mon_addr[base+1] !== 32'h0
            || mon_data[base+1] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL midreset_reload: done %b count %0d addr %h data %h want 1 2 0 deadbeef",
                     done_o, mon_cnt - base, mon_addr[base+1], mon_data[base+1]);
        end
    endtask

    task automatic test_run();
        do_reset();
        run_i = 1'b1;
        @(posedge clk);
        #1 run_i = 1'b0;
        checks++;
        if (done_o !== 1'b1 || core_reset_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL run_release: done %b core_rst %b busy %b want 1 0 0", done_o, core_reset_o, busy_o);
        end
        pulse_start();
        checks++;
        if (done_o !== 1'b0 || core_reset_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL done_restart: done %b core_rst %b busy %b want 0 1 1", done_o, core_reset_o, busy_o);
        end
        do_reset();
        start_i = 1'b1;
        run_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        run_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1 || core_reset_o !== 1'b1 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL start_over_run: busy %b core_rst %b done %b want 1 1 0", busy_o, core_reset_o, done_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  s [14];
        logic [31:0] exp_w [3];
        int base, idx, low, n, t0, t1;
        s = '{8'h03, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01,
              8'h20, 8'h00, 8'hB3, 8'h81, 8'h20, 8'h00};
        exp_w = '{32'h00100093, 32'h00200113, 32'h002081B3};
        do_reset();
        base = mon_cnt;
        pulse_start();
        idx = 0;
        low = 0;
        n = 0;
        t0 = 0;
        bus.byte_valid_i = 1'b1;
        while (idx < 14 && n < 200) begin
            bus.byte_data_i = s[idx];
            @(negedge clk);
            if (bus.byte_ready_o === 1'b1) begin
                if (idx == 0) t0 = cyc;
                idx++;
            end else begin
                low++;
            end
            @(posedge clk);
            #1;
            n++;
        end
        bus.byte_valid_i = 1'b0;
        @(posedge clk);
        #1;
        t1 = cyc;
        checks++;
        if (idx !== 14 || low !== 2) begin
            errors++;
            $display("FAIL b2b_stream: bytes %0d ready_low %0d want 14 2", idx, low);
        end
        // Cycles from the first length transfer cycle through entry to DONE: 2 + 5*3.
        checks++;
        if (done_o !== 1'b1 || t1 - t0 !== 17) begin
            errors++;
            $display("FAIL b2b_total: done %b cycles %0d want 1 17", done_o, t1 - t0);
        end
        checks++;
        if (mon_cnt - base !== 3 || mon_cyc[base+1] - mon_cyc[base] !== 5
            || mon_cyc[base+2] - mon_cyc[base+1] !== 5) begin
            errors++;
            $display("FAIL b2b_spacing: count %0d gaps %0d %0d want 3 5 5", mon_cnt - base,
                     mon_cyc[base+1] - mon_cyc[base], mon_cyc[base+2] - mon_cyc[base+1]);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mon_addr[base+i] !== 32'(i * 4) || mon_data[base+i] !== exp_w[i]) begin
                errors++;
                $display("FAIL b2b_word%0d: addr %h data %h want %h %h", i,
                         mon_addr[base+i], mon_data[base+i], 32'(i * 4), exp_w[i]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start_i = 1'b0;
        run_i = 1'b0;
        bus.byte_valid_i = 1'b0;
        bus.byte_data_i = 8'h00;
        test_reset();
        test_basic_load();
        test_bad_length();
        test_timeout();
        test_reset_mid_load();
        test_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end
endmodule
